if_queue: RTL and testbench
===========================

# if_queue

Decoupling instruction queue between the IFU and the decode/control stage of the pipelined MIPS datapath. Stores up to DEPTH fetched {PC, instruction} pairs under a valid/ready handshake on each side, and drops all of them in one cycle on a branch/jump redirect. Splits the head instruction into the standard MIPS fields so decode reads them directly. Lets fetch run ahead while decode stalls on hazards.

## Interface
- DEPTH, 4, number of entries; power of two, at least 2
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset (0 = reset)
- in_valid  in  1  IFU presents in_pc/in_instr
- in_ready  out  1  queue can accept an entry (= not full)
- in_pc  in  32  PC of fetched instruction
- in_instr  in  32  fetched instruction word
- flush  in  1  redirect: discard all entries and any same-cycle push or pop
- out_valid  out  1  head entry available
- out_ready  in  1  decode consumes head this cycle
- out_pc  out  32  head PC
- out_instr  out  32  head instruction
- out_opcode  out  6  instr[31:26]
- out_rs  out  5  instr[25:21]
- out_rt  out  5  instr[20:16]
- out_rd  out  5  instr[15:11]
- out_shamt  out  5  instr[10:6]
- out_funct  out  6  instr[5:0]
- out_imm16  out  16  instr[15:0]
- out_imm26  out  26  instr[25:0]
- out_adel  out  1  head PC not word-aligned (out_pc[1:0] != 0)
- count  out  $clog2(DEPTH)+1  current occupancy

## Operation
- Circular buffer: write pointer, read pointer, occupancy counter; pointers wrap modulo DEPTH.
- push = in_valid & in_ready & ~flush; pop = out_valid & out_ready & ~flush.
- in_ready = (count != DEPTH). A pop in the same cycle does not raise in_ready when full.
- out_valid = (count != 0). All out_* fields decode from the head entry.
- When out_valid = 0, out_pc and out_instr are 0, so all decoded fields are 0 (a sll $0 nop), and out_adel = 0.
- Push only: store at write pointer, write pointer +1, count +1.
- Pop only: read pointer +1, count −1.
- Push and pop together: both pointers advance and count does not change.
- flush: pointers and count go to 0 next cycle. Flush has priority over push and pop.
- in_valid while full: the entry is not taken. The IFU must hold it; in_ready = 0 shows this.
- out_ready while empty: ignored.
- out_adel is pure decode of the stored PC. The entry is queued normally and exception handling belongs to the consumer.

## Timing
- Reset (reset = 0 at a clk edge): count = 0, pointers = 0, out_valid = 0, in_ready = 1, all out_* = 0. Storage contents are not cleared.
- Reset has priority over flush, push and pop.
- Latency without bypass: an entry pushed at edge N is visible on out_* after edge N, i.e. in cycle N+1.
- Throughput: one push and one pop per cycle sustained when 0 < count < DEPTH.
- in_ready, out_valid and count change only on clk edges.
- The out_* fields are combinational from the registered head entry.
- Reset or flush mid-stream loses all queued entries. No partial drain.

## Configuration
- IF_QUEUE_BYPASS_EN defined:
  - When count = 0 and in_valid = 1 and flush = 0, out_valid = 1 and out_* are driven from in_pc/in_instr in the same cycle.
  - If out_ready = 1 in that cycle, the entry passes straight through and is not stored; count stays 0.
  - If out_ready = 0, it is stored normally.
  - in_ready is unaffected.
- Not defined: no combinational path from in_* to out_*, and minimum latency is 1 cycle.

## Test plan
- Reset and fill:
  - Stimulus: reset = 0 for 2 cycles, then push PC 0x3000/instr 0x3C010001, 0x3004/0x34210002, 0x3008/0x00221820, 0x300C/0x08000C00 with out_ready = 0.
  - Required: count = 4, in_ready = 0.
  - Then a 5th push of 0x3010: not accepted, count stays 4.
- Drain order, with out_ready = 1:
  - Head 0x3000: out_opcode = 0x0F, out_rt = 1, out_imm16 = 0x0001.
  - Then 0x3004 and 0x3008; for 0x3008 out_rs = 1, out_rt = 2, out_rd = 3, out_funct = 0x20.
  - Then 0x300C with out_imm26 = 0x0000C00.
  - Then out_valid = 0 and out_instr = 0.
- Simultaneous push/pop:
  - Stimulus: count = 2, in_valid = out_ready = 1 for 10 cycles with incrementing PCs.
  - Required: count stays 2; PCs pop in order; the pointers wrap past DEPTH without loss.
- Flush priority:
  - Stimulus: count = 3, assert flush with in_valid = out_ready = 1.
  - Required: next cycle count = 0, out_valid = 0; neither the pushed PC nor the popped head reappears.
- Misalignment:
  - Stimulus: push in_pc = 0x3002.
  - Required: at the head, out_adel = 1 and out_pc = 0x3002; the next entry 0x3004 gives out_adel = 0.
- Bypass (IF_QUEUE_BYPASS_EN):
  - Stimulus: empty queue, in_valid = 1, in_pc = 0x3000, out_ready = 1.
  - Required: out_valid = 1 and out_pc = 0x3000 in the same cycle, and count stays 0.
  - Without the macro, out_valid rises one cycle later.

Source files
------------

// File: rtl/if_queue.sv
// ============================================================================
// if_queue -- decoupling instruction queue between the IFU and decode
//
// Holds up to DEPTH fetched {PC, instruction} pairs in a circular buffer with
// valid/ready handshakes on both sides. A redirect (flush) drops every queued
// entry in a single cycle. The head entry is split into the standard MIPS
// instruction fields so decode can use them directly.
//
// Optional feature macro: IF_QUEUE_BYPASS_EN
//   When defined, an empty queue forwards in_pc/in_instr to out_* in the same
//   cycle. If decode also accepts that entry in the same cycle, it is never
//   stored. When the macro is undefined, there is no combinational path from
//   in_* to out_*.
//
// Parameters
//   DEPTH       number of entries (power of two, >= 2)
//
// Ports
//   clk         rising-edge clock
//   reset       synchronous active-low reset (0 = reset)
//   in_valid    IFU presents in_pc/in_instr
//   in_ready    queue can accept an entry (not full)
//   in_pc       PC of fetched instruction
//   in_instr    fetched instruction word
//   flush       redirect: discard all entries and any same-cycle push/pop
//   out_valid   head entry available
//   out_ready   decode consumes head this cycle
//   out_pc      head PC (0 when no head)
//   out_instr   head instruction (0 when no head)
//   out_opcode  instr[31:26]     out_rs    instr[25:21]
//   out_rt      instr[20:16]     out_rd    instr[15:11]
//   out_shamt   instr[10:6]      out_funct instr[5:0]
//   out_imm16   instr[15:0]      out_imm26 instr[25:0]
//   out_adel    head PC not word-aligned
//   count       current occupancy
// ============================================================================
module if_queue #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_pc,
    input  logic [31:0]              in_instr,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_pc,
    output logic [31:0]              out_instr,
    output logic [5:0]               out_opcode,
    output logic [4:0]               out_rs,
    output logic [4:0]               out_rt,
    output logic [4:0]               out_rd,
    output logic [4:0]               out_shamt,
    output logic [5:0]               out_funct,
    output logic [15:0]              out_imm16,
    output logic [25:0]              out_imm26,
    output logic                     out_adel,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);
    localparam logic [AW-1:0] PTR_ZERO = {AW{1'b0}};
    localparam logic [AW-1:0] PTR_ONE  = AW'(1'b1);

    // Storage is never reset; only the pointers and occupancy define validity.
    logic [31:0]   pc_mem_q    [DEPTH];
    logic [31:0]   instr_mem_q [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;

    logic          empty_s;
    logic          full_s;
    logic          bypass_s;
    logic          pass_s;
    logic          push_s;
    logic          pop_s;
    logic [31:0]   head_pc_s;
    logic [31:0]   head_instr_s;

    // Handshake qualification: flush cancels both sides of the transfer.
    always_comb begin
        empty_s = (count_q == CNT_ZERO);
        full_s  = (count_q == CNT_FULL);
`ifdef IF_QUEUE_BYPASS_EN
        // Empty queue forwards the incoming entry; if decode takes it now,
        // it passes straight through and must not also be stored.
        bypass_s = empty_s & in_valid & ~flush;
        pass_s   = bypass_s & out_ready;
`else
        bypass_s = 1'b0;
        pass_s   = 1'b0;
`endif
        push_s = in_valid & ~full_s & ~flush & ~pass_s;
        pop_s  = ~empty_s & out_ready & ~flush;
    end

    // Next-state for pointers and occupancy.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = PTR_ZERO;
            rd_ptr_d = PTR_ZERO;
            count_d  = CNT_ZERO;
        end else begin
            // DEPTH is a power of two, so pointer overflow is the wrap.
            if (push_s) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    // Control state register; reset wins over flush, push and pop.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= PTR_ZERO;
            rd_ptr_q <= PTR_ZERO;
            count_q  <= CNT_ZERO;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage write at the write pointer.
    always_ff @(posedge clk) begin
        if (reset && push_s) begin
            pc_mem_q[wr_ptr_q]    <= in_pc;
            instr_mem_q[wr_ptr_q] <= in_instr;
        end
    end

    // Head selection: stored head, bypassed input, or an all-zero nop.
    always_comb begin
        head_pc_s    = 32'h0000_0000;
        head_instr_s = 32'h0000_0000;
        if (!empty_s) begin
            head_pc_s    = pc_mem_q[rd_ptr_q];
            head_instr_s = instr_mem_q[rd_ptr_q];
        end else if (bypass_s) begin
            head_pc_s    = in_pc;
            head_instr_s = in_instr;
        end else begin
            head_pc_s    = 32'h0000_0000;
            head_instr_s = 32'h0000_0000;
        end
    end

    assign in_ready   = ~full_s;
    assign out_valid  = ~empty_s | bypass_s;
    assign count      = count_q;

    assign out_pc     = head_pc_s;
    assign out_instr  = head_instr_s;
    assign out_opcode = head_instr_s[31:26];
    assign out_rs     = head_instr_s[25:21];
    assign out_rt     = head_instr_s[20:16];
    assign out_rd     = head_instr_s[15:11];
    assign out_shamt  = head_instr_s[10:6];
    assign out_funct  = head_instr_s[5:0];
    assign out_imm16  = head_instr_s[15:0];
    assign out_imm26  = head_instr_s[25:0];
    // head_pc_s is zero when there is no head, so this is 0 when invalid.
    assign out_adel   = (head_pc_s[1:0] != 2'b00);

endmodule

// File: tb/tb_if_queue.sv
// ============================================================================
// tb_if_queue -- self-checking bench for if_queue
//
// Directed sequences for fill, drain/decode, steady push+pop with pointer
// wrap, flush priority, misaligned PC and the bypass path, followed by a
// randomized phase. All outputs are compared every cycle against a queue
// based reference model. Honours IF_QUEUE_BYPASS_EN like the design.
// ============================================================================
module tb_if_queue;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;
`ifdef IF_QUEUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [31:0]   in_pc;
    logic [31:0]   in_instr;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_pc;
    logic [31:0]   out_instr;
    logic [5:0]    out_opcode;
    logic [4:0]    out_rs;
    logic [4:0]    out_rt;
    logic [4:0]    out_rd;
    logic [4:0]    out_shamt;
    logic [5:0]    out_funct;
    logic [15:0]   out_imm16;
    logic [25:0]   out_imm26;
    logic          out_adel;
    logic [CW-1:0] count;

    int checks   = 0;
    int failures = 0;

    // Reference model: FIFO of {pc, instr}.
    logic [63:0] model_q[$];

    if_queue #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_pc      (in_pc),
        .in_instr   (in_instr),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_pc     (out_pc),
        .out_instr  (out_instr),
        .out_opcode (out_opcode),
        .out_rs     (out_rs),
        .out_rt     (out_rt),
        .out_rd     (out_rd),
        .out_shamt  (out_shamt),
        .out_funct  (out_funct),
        .out_imm16  (out_imm16),
        .out_imm26  (out_imm26),
        .out_adel   (out_adel),
        .count      (count)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h expected=0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model update on each rising edge from the inputs held during the cycle.
    always @(posedge clk) begin
        bit pass_b;
        bit push_b;
        bit pop_b;
        if (!reset || flush) begin
            model_q.delete();
        end else begin
            pass_b = BYP && (model_q.size() == 0) && in_valid && out_ready;
            push_b = in_valid && (model_q.size() < DEPTH) && !pass_b;
            pop_b  = out_ready && (model_q.size() > 0);
            if (pop_b) void'(model_q.pop_front());
            if (push_b) model_q.push_back({in_pc, in_instr});
        end
    end

    // Compare every output with what the model predicts for this cycle.
    task automatic check_model();
        logic [31:0] epc;
        logic [31:0] ein;
        logic        ev;
        epc = 32'h0;
        ein = 32'h0;
        ev  = 1'b0;
        if (model_q.size() > 0) begin
            epc = model_q[0][63:32];
            ein = model_q[0][31:0];
            ev  = 1'b1;
        end else if (BYP && in_valid && !flush) begin
            epc = in_pc;
            ein = in_instr;
            ev  = 1'b1;
        end
        check_val("out_valid", 32'(out_valid), 32'(ev));
        check_val("in_ready",  32'(in_ready),  32'(model_q.size() != DEPTH));
        check_val("count",     32'(count),     32'(model_q.size()));
        check_val("out_pc",    out_pc,         epc);
        check_val("out_instr", out_instr,      ein);
        check_val("out_opcode", 32'(out_opcode), 32'(ein[31:26]));
        check_val("out_rs",    32'(out_rs),    32'(ein[25:21]));
        check_val("out_rt",    32'(out_rt),    32'(ein[20:16]));
        check_val("out_rd",    32'(out_rd),    32'(ein[15:11]));
        check_val("out_shamt", 32'(out_shamt), 32'(ein[10:6]));
        check_val("out_funct", 32'(out_funct), 32'(ein[5:0]));
        check_val("out_imm16", 32'(out_imm16), 32'(ein[15:0]));
        check_val("out_imm26", 32'(out_imm26), 32'(ein[25:0]));
        check_val("out_adel",  32'(out_adel),  32'(ev && (epc[1:0] != 2'b00)));
    endtask

    // Drive one cycle of inputs away from the rising edge, then check.
    task automatic step(input logic rst, input logic iv, input logic [31:0] pc,
                        input logic [31:0] ins, input logic ordy, input logic fl);
        @(negedge clk);
        reset     = rst;
        in_valid  = iv;
        in_pc     = pc;
        in_instr  = ins;
        out_ready = ordy;
        flush     = fl;
        #1;
        check_model();
    endtask

    initial begin
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_pc     = 32'h0;
        in_instr  = 32'h0;
        out_ready = 1'b0;
        flush     = 1'b0;

        // Reset for two cycles
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        check_val("rst_count",     32'(count),     32'd0);
        check_val("rst_in_ready",  32'(in_ready),  32'd1);
        check_val("rst_out_valid", 32'(out_valid), 32'd0);

        // Fill with decode stalled
        step(1'b1, 1'b1, 32'h3000, 32'h3C01_0001, 1'b0, 1'b0);
        step(1'b1, 1'b1, 32'h3004, 32'h3421_0002, 1'b0, 1'b0);
        step(1'b1, 1'b1, 32'h3008, 32'h0022_1820, 1'b0, 1'b0);
        step(1'b1, 1'b1, 32'h300C, 32'h0800_0C00, 1'b0, 1'b0);
        step(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        check_val("fill_count", 32'(count),    32'd4);
        check_val("fill_ready", 32'(in_ready), 32'd0);
        step(1'b1, 1'b1, 32'h3010, 32'h0000_0000, 1'b0, 1'b0);
        step(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        check_val("full_push_count", 32'(count), 32'd4);

        // Drain in order
        step(1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        check_val("d0_pc",     out_pc,              32'h3000);
        check_val("d0_opcode", 32'(out_opcode),     32'h0F);
        check_val("d0_rt",     32'(out_rt),         32'd1);
        check_val("d0_imm16",  32'(out_imm16),      32'h0001);
        step(1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        check_val("d1_pc",     out_pc,              32'h3004);
        step(1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        check_val("d2_pc",     out_pc,              32'h3008);
        check_val("d2_rs",     32'(out_rs),         32'd1);
        check_val("d2_rt",     32'(out_rt),         32'd2);
        check_val("d2_rd",     32'(out_rd),         32'd3);
        check_val("d2_funct",  32'(out_funct),      32'h20);
        step(1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        check_val("d3_pc",     out_pc,              32'h300C);
        check_val("d3_imm26",  32'(out_imm26),      32'h000_0C00);
        step(1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        check_val("d4_valid",  32'(out_valid),      32'd0);
        check_val("d4_instr",  out_instr,           32'h0);

        // Steady push+pop at count 2; pointers wrap several times
        step(1'b1, 1'b1, 32'h4000, 32'h1000_0000, 1'b0, 1'b0);
        step(1'b1, 1'b1, 32'h4004, 32'h1000_0001, 1'b0, 1'b0);
        for (int k = 0; k < 10; k++) begin
            step(1'b1, 1'b1, 32'h4008 + 32'(4 * k), 32'h1000_0002 + 32'(k), 1'b1, 1'b0);
            check_val("pp_count", 32'(count), 32'd2);
            check_val("pp_pc",    out_pc,     32'h4000 + 32'(4 * k));
        end
        step(1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Flush with simultaneous push and pop at count 3
        step(1'b1, 1'b1, 32'h5000, 32'h2000_0000, 1'b0, 1'b0);
        step(1'b1, 1'b1, 32'h5004, 32'h2000_0001, 1'b0, 1'b0);
        step(1'b1, 1'b1, 32'h5008, 32'h2000_0002, 1'b0, 1'b0);
        step(1'b1, 1'b1, 32'h500C, 32'h2000_0003, 1'b1, 1'b1);
        check_val("pre_flush_count", 32'(count), 32'd3);
        step(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        check_val("flush_count", 32'(count),     32'd0);
        check_val("flush_valid", 32'(out_valid), 32'd0);
        step(1'b1, 1'b1, 32'h6000, 32'h2400_0000, 1'b0, 1'b0);
        step(1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        check_val("post_flush_pc", out_pc, 32'h6000);
        step(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

        // Misaligned PC
        step(1'b1, 1'b1, 32'h3002, 32'h0000_0000, 1'b0, 1'b0);
        step(1'b1, 1'b1, 32'h3004, 32'h0000_0000, 1'b0, 1'b0);
        step(1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        check_val("adel_hi", 32'(out_adel), 32'd1);
        check_val("adel_pc", out_pc,        32'h3002);
        step(1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        check_val("adel_lo", 32'(out_adel), 32'd0);
        check_val("adel_pc2", out_pc,       32'h3004);
        step(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

        // Bypass behaviour on an empty queue
        step(1'b1, 1'b1, 32'h3000, 32'h3C01_0001, 1'b1, 1'b0);
        check_val("byp_count", 32'(count), 32'd0);
`ifdef IF_QUEUE_BYPASS_EN
        check_val("byp_valid", 32'(out_valid), 32'd1);
        check_val("byp_pc",    out_pc,         32'h3000);
        step(1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        check_val("byp_after_count", 32'(count),     32'd0);
        check_val("byp_after_valid", 32'(out_valid), 32'd0);
`else
        check_val("nobyp_valid", 32'(out_valid), 32'd0);
        step(1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        check_val("nobyp_valid1", 32'(out_valid), 32'd1);
        check_val("nobyp_pc1",    out_pc,         32'h3000);
        step(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        check_val("nobyp_count2", 32'(count), 32'd0);
`endif

        // Randomized traffic with phases biased toward full and empty
        for (int i = 0; i < 3000; i++) begin
            int phase;
            logic rst_r;
            logic iv_r;
            logic ordy_r;
            logic fl_r;
            phase  = (i / 250) % 3;
            rst_r  = ($urandom_range(0, 199) != 0);
            fl_r   = ($urandom_range(0, 19) == 0);
            iv_r   = ($urandom_range(0, 99) < ((phase == 0) ? 85 : (phase == 1) ? 30 : 60));
            ordy_r = ($urandom_range(0, 99) < ((phase == 0) ? 30 : (phase == 1) ? 85 : 60));
            step(rst_r, iv_r, $urandom, $urandom, ordy_r, fl_r);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
